// File: rtl/serial_add_pkg.sv
// Shared types and constants for the serial nibble adder.
// Holds the slice width and the controller state encoding.
// Imported by the controller and its adder slice.
package serial_add_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_adder_slice.sv
// 4-bit ripple-carry adder slice built from four full-adder stages.
// Latency: purely combinational.
// Backpressure: none; the controller decides when the result is used.
module nibble_adder_slice
    import serial_add_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                ci,
    output logic [NIBBLE_W-1:0] s,
    output logic                co
);

    logic [NIBBLE_W:0] c;

    assign c[0] = ci;

    // One full adder per bit; the carry ripples upward through c[].
    for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
        assign s[i]     = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign co = c[NIBBLE_W];

endmodule

// File: rtl/serial_nibble_add_ctrl.sv
// Multi-word adder that reuses one 4-bit slice per nibble, LSB nibble first.
// Latency: NIBBLES+1 cycles from accept edge to done_o; one op per NIBBLES+2 cycles.
// Backpressure: start_i is only sampled in IDLE; requests while busy are dropped.
// Optional: define SERIAL_ADD_OVF_DETECT_EN to add the signed-overflow output ovf_o.
module serial_nibble_add_ctrl
    import serial_add_pkg::*;
#(
    parameter  int NIBBLES = 4,
    localparam int W       = NIBBLE_W * NIBBLES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic         busy_o,
    output logic         done_o,
    output logic [W-1:0] sum_o,
`ifdef SERIAL_ADD_OVF_DETECT_EN
    output logic         cout_o,
    output logic         ovf_o
`else
    output logic         cout_o
`endif
);

    localparam int               IDX_W = $clog2(NIBBLES);
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(NIBBLES - 1);

    state_t                             state_q;
    logic [NIBBLES-1:0][NIBBLE_W-1:0]   a_q;
    logic [NIBBLES-1:0][NIBBLE_W-1:0]   b_q;
    logic [NIBBLES-1:0][NIBBLE_W-1:0]   acc_q;
    logic                               carry_q;
    logic [IDX_W-1:0]                   idx_q;
    logic [IDX_W-1:0]                   idx_d;
    logic [W-1:0]                       sum_q;
    logic                               cout_q;
    logic                               done_q;
    logic                               busy_q;
    logic [NIBBLE_W-1:0]                slice_s;
    logic                               slice_co;
`ifdef SERIAL_ADD_OVF_DETECT_EN
    logic                               ovf_q;
    logic                               ovf_out_q;
`endif

    assign idx_d = idx_q + 1'b1;

    // The single shared slice always works on the nibble selected by idx_q.
    nibble_adder_slice u_slice (
        .a  (a_q[idx_q]),
        .b  (b_q[idx_q]),
        .ci (carry_q),
        .s  (slice_s),
        .co (slice_co)
    );

    // Sequencer: capture on accept, one nibble per RUN cycle, publish in DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            carry_q   <= 1'b0;
            idx_q     <= '0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
`ifdef SERIAL_ADD_OVF_DETECT_EN
            ovf_q     <= 1'b0;
            ovf_out_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // busy stays high through the done pulse only if a new op is taken
                    busy_q <= start_i;
                    if (start_i) begin
                        a_q     <= a_i;
                        b_q     <= b_i;
                        carry_q <= cin_i;
                        idx_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    acc_q[idx_q] <= slice_s;
                    carry_q      <= slice_co;
                    if (idx_q == LAST) begin
                        idx_q   <= '0;
                        state_q <= DONE;
`ifdef SERIAL_ADD_OVF_DETECT_EN
                        ovf_q   <= (a_q[NIBBLES-1][NIBBLE_W-1] == b_q[NIBBLES-1][NIBBLE_W-1]) &&
                                   (slice_s[NIBBLE_W-1] != a_q[NIBBLES-1][NIBBLE_W-1]);
`endif
                    end else begin
                        idx_q <= idx_d;
                    end
                end
                DONE: begin
                    sum_q     <= acc_q;
                    cout_q    <= carry_q;
                    done_q    <= 1'b1;
                    state_q   <= IDLE;
`ifdef SERIAL_ADD_OVF_DETECT_EN
                    ovf_out_q <= ovf_q;
`endif
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = done_q;
    assign sum_o  = sum_q;
    assign cout_o = cout_q;
`ifdef SERIAL_ADD_OVF_DETECT_EN
    assign ovf_o  = ovf_out_q;
`endif

endmodule

// File: tb/tb_serial_nibble_add_ctrl.sv
// Directed bench for serial_nibble_add_ctrl (NIBBLES=4) with a cycle model.
// The model works from accept times and whole-word arithmetic.
// Optional ovf_o checks follow SERIAL_ADD_OVF_DETECT_EN.
module tb_serial_nibble_add_ctrl;

    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_i;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         cin_i;
    logic         busy_o;
    logic         done_o;
    logic [W-1:0] sum_o;
    logic         cout_o;
`ifdef SERIAL_ADD_OVF_DETECT_EN
    logic         ovf_o;
`endif

    int checks   = 0;
    int failures = 0;

    serial_nibble_add_ctrl #(.NIBBLES(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .start_i (start_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .cin_i   (cin_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .sum_o   (sum_o),
`ifdef SERIAL_ADD_OVF_DETECT_EN
        .cout_o  (cout_o),
        .ovf_o   (ovf_o)
`else
        .cout_o  (cout_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // An op accepted at edge T publishes its whole-word sum at edge T+N+1;
    // busy covers the cycles after edges T..T+N+1; start is only honoured
    // when no op is in flight.
    int           edge_n   = 0;
    bit           m_active = 1'b0;
    int           m_acc    = 0;
    logic [W-1:0] m_a, m_b;
    logic         m_cin;
    logic [W:0]   m_full;
    logic [W-1:0] exp_sum  = '0;
    logic         exp_cout = 1'b0;
    logic         exp_ovf  = 1'b0;
    logic         exp_done = 1'b0;
    logic         exp_busy = 1'b0;

    always @(posedge clk) begin
        edge_n++;
        if (rst) begin
            m_active = 1'b0;
            exp_sum  = '0;
            exp_cout = 1'b0;
            exp_ovf  = 1'b0;
            exp_done = 1'b0;
            exp_busy = 1'b0;
        end else begin
            exp_done = 1'b0;
            if (m_active) begin
                exp_busy = 1'b1;
                if (edge_n == m_acc + N + 1) begin
                    m_full   = {1'b0, m_a} + {1'b0, m_b} + {{W{1'b0}}, m_cin};
                    exp_sum  = m_full[W-1:0];
                    exp_cout = m_full[W];
                    exp_ovf  = (m_a[W-1] == m_b[W-1]) && (m_full[W-1] != m_a[W-1]);
                    exp_done = 1'b1;
                    m_active = 1'b0;
                end
            end else if (start_i) begin
                m_a      = a_i;
                m_b      = b_i;
                m_cin    = cin_i;
                m_acc    = edge_n;
                m_active = 1'b1;
                exp_busy = 1'b1;
            end else begin
                exp_busy = 1'b0;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (edge_n > 0) begin
            chk("cyc_done", 32'(done_o), 32'(exp_done));
            chk("cyc_busy", 32'(busy_o), 32'(exp_busy));
            chk("cyc_sum",  32'(sum_o),  32'(exp_sum));
            chk("cyc_cout", 32'(cout_o), 32'(exp_cout));
`ifdef SERIAL_ADD_OVF_DETECT_EN
            chk("cyc_ovf",  32'(ovf_o),  32'(exp_ovf));
`endif
        end
    end

    // ---------------- directed stimulus ----------------
    // Presents an op for one edge; returns at the negedge after the accept edge.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        start_i = 1'b1;
        a_i     = a;
        b_i     = b;
        cin_i   = c;
        @(negedge clk);
        start_i = 1'b0;
        a_i     = $urandom();
        b_i     = $urandom();
        cin_i   = 1'($urandom());
    endtask

    // Called at the negedge after the accept edge; expects done 5 edges later.
    task automatic wait_done(input string name, input logic [W-1:0] s, input logic co);
        int k = 0;
        while (!done_o && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!done_o) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=no_done required=done_within_20", name);
        end else begin
            chk({name, "_lat"},  32'(k),      32'(N + 1));
            chk({name, "_sum"},  32'(sum_o),  32'(s));
            chk({name, "_cout"}, 32'(cout_o), 32'(co));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        start_i = 1'b0;
        a_i     = '0;
        b_i     = '0;
        cin_i   = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_sum",  32'(sum_o),  32'h0);
        chk("rst_cout", 32'(cout_o), 32'h0);
        chk("rst_busy", 32'(busy_o), 32'h0);
        chk("rst_done", 32'(done_o), 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        start_op(16'h1234, 16'h4321, 1'b0);
        chk("t1_busy", 32'(busy_o), 32'h1);
        wait_done("t1", 16'h5555, 1'b0);
        @(negedge clk);
        chk("t1_pulse", 32'(done_o), 32'h0);
        chk("t1_hold",  32'(sum_o),  32'h5555);

        start_op(16'hFFFF, 16'h0001, 1'b0);
        wait_done("t2", 16'h0000, 1'b1);
        @(negedge clk);

        start_op(16'hFFFF, 16'h0000, 1'b1);
        wait_done("t3a", 16'h0000, 1'b1);
        @(negedge clk);
        start_op(16'h0F0F, 16'h00F1, 1'b0);
        wait_done("t3b", 16'h1000, 1'b0);
        @(negedge clk);

        // start held high through busy with different operands
        start_i = 1'b1;
        a_i     = 16'h0001;
        b_i     = 16'h0001;
        cin_i   = 1'b0;
        @(negedge clk);
        a_i = 16'h1111;
        b_i = 16'h1111;
        wait_done("t4a", 16'h0002, 1'b0);
        @(negedge clk);
        start_i = 1'b0;
        wait_done("t4b", 16'h2222, 1'b0);
        @(negedge clk);

        // reset during the second RUN cycle aborts the op
        start_op(16'h8000, 16'h8000, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_sum",  32'(sum_o),  32'h0);
        chk("t5_busy", 32'(busy_o), 32'h0);
        chk("t5_done", 32'(done_o), 32'h0);
        repeat (8) @(negedge clk);
        start_op(16'h0003, 16'h0004, 1'b0);
        wait_done("t5b", 16'h0007, 1'b0);
        @(negedge clk);

        start_op(16'h7FFF, 16'h0001, 1'b0);
        wait_done("t6", 16'h8000, 1'b0);
`ifdef SERIAL_ADD_OVF_DETECT_EN
        chk("t6_ovf", 32'(ovf_o), 32'h1);
`endif
        @(negedge clk);
        start_op(16'h8000, 16'h8000, 1'b0);
        wait_done("t7", 16'h0000, 1'b1);
`ifdef SERIAL_ADD_OVF_DETECT_EN
        chk("t7_ovf", 32'(ovf_o), 32'h1);
`endif
        @(negedge clk);
        start_op(16'h0001, 16'h0001, 1'b0);
        wait_done("t8", 16'h0002, 1'b0);
`ifdef SERIAL_ADD_OVF_DETECT_EN
        chk("t8_ovf", 32'(ovf_o), 32'h0);
`endif

        repeat (4) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
